// File: rtl/pll_lock_monitor.sv
// Lock monitor for a PLL output clock: measures REF period in CLK cycles and
// declares lock after LOCK_CNT consecutive in-tolerance periods.
module pll_lock_monitor #(
   parameter int MULT     = 8,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 12
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             REF,
   output logic             LOCKED,
   output logic             CLK_EN,
   output logic [CNT_W-1:0] PERIOD_CNT,
   output logic             PERIOD_VALID,
   output logic             LOCK_LOST
);

   localparam int GC_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_LO  = CNT_W'(MULT - TOL);
   localparam logic [CNT_W-1:0] CNT_HI  = CNT_W'(MULT + TOL);
   localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MULT + TOL + 1);
   localparam logic [GC_W-1:0]  GC_LAST = GC_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_EDGE, S_MEASURE, S_LOCKED} state_t;

   state_t           r_state;
   logic             r_s1, r_s2, r_s3;
   logic [CNT_W-1:0] r_cnt;
   logic [GC_W-1:0]  r_good_cnt;
   logic             w_edge, w_good, w_tmo;

   // REF is asynchronous; s1/s2 synchronise, s3 is history for edge detect
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= REF;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge = r_s2 & ~r_s3;
   assign w_good = (r_cnt >= CNT_LO) && (r_cnt <= CNT_HI);
   assign w_tmo  = ~w_edge && (r_cnt == CNT_TMO);

   always_ff @(posedge CLK) begin
      if (RST)                  r_cnt <= '0;
      else if (w_edge)          r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_good_cnt   <= '0;
         LOCKED       <= 1'b0;
         CLK_EN       <= 1'b0;
         LOCK_LOST    <= 1'b0;
         PERIOD_VALID <= 1'b0;
         PERIOD_CNT   <= '0;
      end else begin
         PERIOD_VALID <= 1'b0;
         if (!EN) begin
            r_state    <= S_IDLE;
            r_good_cnt <= '0;
            LOCKED     <= 1'b0;
            CLK_EN     <= 1'b0;
            LOCK_LOST  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state    <= S_WAIT_EDGE;
                  r_good_cnt <= '0;
               end
               // first edge only starts the count; there is no period yet
               S_WAIT_EDGE: begin
                  if (w_edge) begin
                     r_state    <= S_MEASURE;
                     r_good_cnt <= '0;
                  end
               end
               S_MEASURE: begin
                  if (w_edge) begin
                     PERIOD_CNT   <= r_cnt;
                     PERIOD_VALID <= 1'b1;
                     if (!w_good) begin
                        r_good_cnt <= '0;
                     end else if (r_good_cnt == GC_LAST) begin
                        r_state    <= S_LOCKED;
                        r_good_cnt <= '0;
                        LOCKED     <= 1'b1;
                        CLK_EN     <= 1'b1;
                     end else begin
                        r_good_cnt <= r_good_cnt + 1'b1;
                     end
                  end else if (w_tmo) begin
                     r_state    <= S_WAIT_EDGE;
                     r_good_cnt <= '0;
                  end
               end
               S_LOCKED: begin
                  if (w_edge) begin
                     PERIOD_CNT   <= r_cnt;
                     PERIOD_VALID <= 1'b1;
                     if (!w_good) begin
                        r_state    <= S_MEASURE;
                        r_good_cnt <= '0;
                        LOCKED     <= 1'b0;
                        CLK_EN     <= 1'b0;
                        LOCK_LOST  <= 1'b1;
                     end
                  end else if (w_tmo) begin
                     r_state    <= S_WAIT_EDGE;
                     r_good_cnt <= '0;
                     LOCKED     <= 1'b0;
                     CLK_EN     <= 1'b0;
                     LOCK_LOST  <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor; measured periods are checked through a
// scoreboard queue filled as REF edges are driven.
module tb_pll_lock_monitor;

   localparam int CNT_W = 12;

   logic             clk = 1'b0;
   logic             rst, en, ref_i;
   logic             locked, clk_en, period_valid, lock_lost;
   logic [CNT_W-1:0] period_cnt;

   int n_vec = 0;
   int n_err = 0;
   int sb[$];
   int last_p = 0;

   pll_lock_monitor #(.MULT(8), .TOL(1), .LOCK_CNT(4), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST(rst), .EN(en), .REF(ref_i),
      .LOCKED(locked), .CLK_EN(clk_en), .PERIOD_CNT(period_cnt),
      .PERIOD_VALID(period_valid), .LOCK_LOST(lock_lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One REF period of p cycles starting with a rising edge. If counted, the
   // edge closes the previous period, so last_p is expected on PERIOD_CNT.
   // LOCKED is checked 2 and 3 samples after the edge (-1 skips).
   task automatic period(input int p, input bit counted, input int exp_before, input int exp_after);
      ref_i = 1'b1;
      if (counted) sb.push_back(last_p);
      last_p = p;
      for (int i = 0; i < p; i++) begin
         if (i == p / 2) ref_i = 1'b0;
         tick();
         if (i == 1 && exp_before >= 0) chk("locked_before", 32'(locked), 32'(exp_before));
         if (i == 2 && exp_after >= 0) begin
            chk("locked_after", 32'(locked), 32'(exp_after));
            chk("clk_en_after", 32'(clk_en), 32'(exp_after));
         end
      end
   endtask

   task automatic relock8();
      period(8, 1'b0, -1, -1);
      period(8, 1'b1, -1, -1);
      period(8, 1'b1, -1, -1);
      period(8, 1'b1, -1, -1);
      period(8, 1'b1, 0, 1);
   endtask

   always @(negedge clk) begin
      if (period_valid === 1'b1) begin
         n_vec++;
         assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_valid: observed PERIOD_CNT %0d expected no pulse", period_cnt);
         end
         if (sb.size() > 0) chk("period_cnt", 32'(period_cnt), 32'(sb.pop_front()));
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; ref_i = 1'b0;
      repeat (3) tick();
      chk("rst_locked", 32'(locked), 0);
      chk("rst_clk_en", 32'(clk_en), 0);
      chk("rst_period_cnt", 32'(period_cnt), 0);
      chk("rst_valid", 32'(period_valid), 0);
      chk("rst_lock_lost", 32'(lock_lost), 0);

      // nominal lock: 5 edges of period 8
      rst = 1'b0; en = 1'b1;
      tick();
      relock8();
      chk("lock_lost_clean", 32'(lock_lost), 0);
      period(8, 1'b1, 1, 1);

      // one long period of 10 drops lock, then relock with LOCK_LOST sticky
      period(10, 1'b1, 1, 1);
      period(8, 1'b1, 1, 0);
      chk("lock_lost_set", 32'(lock_lost), 1);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, 0, 1);
      chk("lock_lost_sticky", 32'(lock_lost), 1);

      // single-cycle EN drop clears flags but holds PERIOD_CNT
      en = 1'b0;
      tick();
      chk("en0_locked", 32'(locked), 0);
      chk("en0_clk_en", 32'(clk_en), 0);
      chk("en0_lock_lost", 32'(lock_lost), 0);
      chk("en0_period_cnt", 32'(period_cnt), 8);
      en = 1'b1;
      tick();
      relock8();
      chk("relock_lost", 32'(lock_lost), 0);

      // tolerance edges 7/9 are all good
      en = 1'b0; tick(); en = 1'b1; tick();
      period(7, 1'b0, -1, -1);
      period(9, 1'b1, -1, 0);
      period(7, 1'b1, -1, 0);
      period(9, 1'b1, -1, 0);
      period(7, 1'b1, 0, 1);

      // a period of 6 restarts the good count
      en = 1'b0; tick(); en = 1'b1; tick();
      period(8, 1'b0, -1, -1);
      period(8, 1'b1, -1, 0);
      period(6, 1'b1, -1, 0);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, -1, 0);
      period(8, 1'b1, 0, 1);

      // REF held low: counter reaches 10 after sample 12, lock drops at 13
      repeat (4) tick();
      chk("tmo_still_locked", 32'(locked), 1);
      tick();
      chk("tmo_locked", 32'(locked), 0);
      chk("tmo_clk_en", 32'(clk_en), 0);
      chk("tmo_lock_lost", 32'(lock_lost), 1);
      chk("tmo_valid", 32'(period_valid), 0);
      repeat (6) tick();
      // back in WAIT_EDGE: first edge yields no pulse
      relock8();

      // reset lands on the cycle the synchronised edge would be acted on
      ref_i = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("rstedge_locked", 32'(locked), 0);
      chk("rstedge_clk_en", 32'(clk_en), 0);
      chk("rstedge_valid", 32'(period_valid), 0);
      chk("rstedge_lost", 32'(lock_lost), 0);
      chk("rstedge_period_cnt", 32'(period_cnt), 0);
      ref_i = 1'b0; rst = 1'b0;
      repeat (5) tick();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pll_lock_monitor.md
Name: pll_lock_monitor

Overview:
- Downstream consumer of the avsd_pll_1v8 output clock. Runs on the PLL output CLK and samples the PLL reference REF as data.
- Measures the number of CLK cycles per REF period and declares lock after LOCK_CNT consecutive in-tolerance periods.
- Drives LOCKED and CLK_EN, which gate the RISC-V core clock enable.
- Drops lock on any out-of-tolerance period or missing REF edge.

Parameters:
MULT, 8, expected CLK cycles per REF period (PLL multiplication ratio)
TOL, 1, allowed deviation from MULT in CLK cycles, inclusive
LOCK_CNT, 4, consecutive good periods required to assert LOCKED
CNT_W, 12, width of period counter and PERIOD_CNT; must hold MULT+TOL+1

Ports:
CLK  input  1  PLL output clock, sole clock
RST  input  1  synchronous active-high reset
EN  input  1  monitor enable, tied to EN_VCO; low forces IDLE
REF  input  1  PLL reference clock, asynchronous to CLK, sampled as data
LOCKED  output  1  PLL declared locked
CLK_EN  output  1  downstream clock enable; equals LOCKED, registered
PERIOD_CNT  output  CNT_W  last measured REF period in CLK cycles
PERIOD_VALID  output  1  one-cycle pulse when PERIOD_CNT updates
LOCK_LOST  output  1  sticky; set on LOCKED 1->0 by fault; cleared by RST or EN low

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset is synchronous and active-high on RST.
  - RST=1 at a CLK edge: all outputs 0, state IDLE, counters 0.
- REF synchroniser and edge detect:
  - REF passes through a 2-flop synchroniser plus one history flop.
  - edge = s2 & ~s3, i.e. a rising REF edge.
  - Fixed 3-cycle latency; it cancels out of period measurement.
- Period counter cnt:
  - On an edge cycle, cnt <= 1. Otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - On an edge at cycle t1 following an edge at t0, the measured period is t1-t0, the value of cnt at t1.
- Classification:
  - good = |period - MULT| <= TOL.
  - Timeout: no edge in the current cycle and cnt == MULT+TOL+1.
  - Edge takes priority over timeout in the same cycle.
- FSM states IDLE, WAIT_EDGE, MEASURE, LOCKED:
  - IDLE: EN=1 -> WAIT_EDGE. Outputs 0 and good_cnt 0.
  - WAIT_EDGE: edge -> MEASURE, cnt <= 1, good_cnt 0. No PERIOD_VALID on this first edge.
  - MEASURE, on edge: PERIOD_CNT <= cnt and PERIOD_VALID=1 next cycle.
    - If good: good_cnt+1. When good_cnt reaches LOCK_CNT -> LOCKED, with LOCKED/CLK_EN=1 from the next cycle.
    - If bad: good_cnt <= 0 and stay in MEASURE.
  - MEASURE, on timeout -> WAIT_EDGE, good_cnt 0.
  - LOCKED, on good edge: stay locked and update PERIOD_CNT.
  - LOCKED, on bad edge: -> MEASURE, good_cnt 0, LOCKED/CLK_EN=0 next cycle, LOCK_LOST<=1.
  - LOCKED, on timeout: -> WAIT_EDGE, LOCKED/CLK_EN=0 next cycle, LOCK_LOST<=1.
  - Any state, EN=0: -> IDLE next cycle; LOCKED, CLK_EN, LOCK_LOST, PERIOD_VALID, good_cnt cleared. PERIOD_CNT holds its value.
  - Reset mid-operation overrides everything, including a simultaneous edge.
- PERIOD_VALID: exactly one cycle per counted edge in MEASURE or LOCKED. Never asserted in IDLE or WAIT_EDGE.
- Saturation: when cnt is saturated, PERIOD_CNT reports 2^CNT_W-1. This is reachable only if the timeout is disabled by parameters.

Test Plan:
- Common settings: MULT=8, TOL=1, LOCK_CNT=4, RST released, EN=1.
- REF toggles every 4 CLK (period 8) -> PERIOD_CNT=8 with PERIOD_VALID pulses; LOCKED=CLK_EN=1 one cycle after the 5th synchronised edge; LOCK_LOST=0.
- Locked, then one REF period of 10 CLK -> PERIOD_CNT=10; LOCKED=0 next cycle; LOCK_LOST=1. After 4 further periods of 8, relock, with LOCK_LOST still 1.
- Periods 7 and 9 alternating -> all good, lock after 4 periods. Period 6 or 10 anywhere in the sequence -> good_cnt resets, no lock until 4 consecutive good periods.
- Locked, then REF held low -> timeout when cnt=10 with no edge; LOCKED=0 the following cycle; state WAIT_EDGE; no PERIOD_VALID.
- Locked, then EN=0 for 1 cycle -> LOCKED, CLK_EN, LOCK_LOST=0 next cycle; PERIOD_CNT retains 8. EN=1 -> full 5-edge relock.
- RST=1 coincident with a REF edge while locked -> all outputs 0 next cycle; PERIOD_VALID not asserted.
